// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
//   Shared types and constants for the instruction-memory loader slice.
//   - IMEM_DEPTH : default instruction memory depth in words
//   - WORD_W     : instruction word width
//   - BYTE_W     : stream byte width
//   - CNT_W      : width able to hold a word count of 0..IMEM_DEPTH
//   - state_t    : loader FSM states
// ---------------------------------------------------------------------------
package imem_pkg;

  localparam int IMEM_DEPTH = 1024;
  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int CNT_W      = $clog2(IMEM_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
//   Collects four stream bytes, MSB first, into one 32-bit word.
//   Ports:
//     clk        in   clock
//     rst_n      in   synchronous active-low reset
//     clear      in   drop any partial word and restart at byte 0
//     byte_en    in   a byte is transferred this cycle
//     byte_data  in   the transferred byte
//     word_valid out  high in the cycle the 4th byte is transferred
//     word       out  assembled word (valid with word_valid)
//   word_valid/word are combinational so the consumer can register the
//   result on the same edge that takes the 4th byte.
// ---------------------------------------------------------------------------
module word_assembler
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-BYTE_W-1:0] shreg;
  logic [1:0]               idx;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shreg <= '0;
      idx   <= '0;
    end else if (byte_en) begin
      shreg <= {shreg[WORD_W-2*BYTE_W-1:0], byte_data};
      idx   <= idx + 2'd1;
    end
  end

  assign word_valid = byte_en && (idx == 2'd3);
  assign word       = {shreg, byte_data};

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Receives a program image as a valid/ready byte stream and writes it into
//   instruction memory as big-endian 32-bit words.
//   Image: 4-byte word count N, then N words (MSB first). With the
//   LOADER_CHECKSUM_EN macro defined, a 4-byte trailer follows that must equal
//   the mod-2^32 sum of the N words.
//   Parameters: DEPTH (max words), BASE_ADDR (first word index), ADDR_W.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     start        begin a load (ignored while busy)
//     byte_valid   stream byte present
//     byte_data    stream byte
//     byte_ready   loader accepts bytes (HDR/DATA/CSUM)
//     wr_en        one-cycle write strobe, the cycle after a word completes
//     wr_addr      BASE_ADDR + word number (wraps at ADDR_W bits)
//     wr_data      assembled word
//     busy         same as byte_ready; holds the CPU off
//     done / err   load finished OK / image rejected; held until next start
// ---------------------------------------------------------------------------
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH     = IMEM_DEPTH,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t            state;
  logic [CW-1:0]     n_words;
  logic [CW-1:0]     wcnt;
  logic              xfer;
  logic              load_go;
  logic              word_valid;
  logic [WORD_W-1:0] word;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
`endif

  assign xfer    = byte_valid && byte_ready;
  // byte_ready is low exactly in IDLE/DONE/ERR, the states that honour start.
  assign load_go = start && !byte_ready;
  assign busy    = byte_ready;

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (load_go),
    .byte_en    (xfer),
    .byte_data  (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      n_words    <= '0;
      wcnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      // Strobe defaults low; only a completed data word raises it.
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= HDR;
            byte_ready <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            wcnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
          end
        end
        HDR: begin
          if (word_valid) begin
            n_words <= word[CW-1:0];
            if (word > WORD_W'(DEPTH)) begin
              state      <= ERR;
              byte_ready <= 1'b0;
              err        <= 1'b1;
            end else if (word == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CSUM;
`else
              state      <= DONE;
              byte_ready <= 1'b0;
              done       <= 1'b1;
`endif
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (word_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(wcnt);
            wr_data <= word;
            wcnt    <= wcnt + CW'(1);
`ifdef LOADER_CHECKSUM_EN
            sum     <= sum + word;
`endif
            if (wcnt == n_words - CW'(1)) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CSUM;
`else
              state      <= DONE;
              byte_ready <= 1'b0;
              done       <= 1'b1;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (word_valid) begin
            byte_ready <= 1'b0;
            if (word == sum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Directed + randomized bench for imem_loader. The reference model builds
//   each image as a byte queue and derives the expected writes, checksum and
//   final status from the image format itself. Works with or without
//   LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int DEPTH  = 1024;
  localparam int BASE   = 0;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          hs;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  int          hs_cnt = 0;
  int          hs_base;
  wr_t         cap_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] word_list[$];
  logic [31:0] exp_q[$];
  bit          exp_done;
  bit          exp_err;

  // Handshake counter and write monitor.
  always @(posedge clk) if (byte_valid && byte_ready) hs_cnt++;
  always @(negedge clk) if (wr_en === 1'b1) cap_q.push_back('{wr_addr, wr_data, hs_cnt});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    tx_q.push_back(w[31:24]);
    tx_q.push_back(w[23:16]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[7:0]);
  endtask

  // Reference model: turns word_list into a byte image and predicts the
  // writes and the final status straight from the image format.
  task automatic build_image(input logic [31:0] hdr_n, input bit use_trailer, input logic [31:0] trailer);
    logic [31:0] s = 32'd0;
    tx_q.delete();
    exp_q.delete();
    push_word(hdr_n);
    if (hdr_n > DEPTH) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
    end else begin
      foreach (word_list[i]) begin
        push_word(word_list[i]);
        exp_q.push_back(word_list[i]);
        s = s + word_list[i];
      end
`ifdef LOADER_CHECKSUM_EN
      push_word(use_trailer ? trailer : s);
      exp_done = use_trailer ? (trailer == s) : 1'b1;
`else
      exp_done = 1'b1;
`endif
      exp_err = !exp_done;
    end
  endtask

  task automatic rand_words(input int n);
    word_list.delete();
    for (int i = 0; i < n; i++) word_list.push_back($urandom);
  endtask

  task automatic begin_load();
    @(negedge clk);
    start   = 1'b1;
    hs_base = hs_cnt;
    cap_q.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers up to max_bytes bytes from tx_q; gap idle cycles between bytes,
  // optionally pulsing start inside each gap.
  task automatic feed(input int gap, input bit poke, input int max_bytes);
    int sent = 0;
    int guard;
    bit rdy;
    while (tx_q.size() > 0 && sent < max_bytes) begin
      @(negedge clk);
      start      = 1'b0;
      byte_valid = 1'b1;
      byte_data  = tx_q[0];
      guard      = 0;
      forever begin
        rdy = byte_ready;
        @(posedge clk);
        if (rdy || guard >= 50) break;
        guard++;
        @(negedge clk);
      end
      if (!rdy) begin
        check("feed_stall", 64'(rdy), 64'd1);
        tx_q.delete();
        break;
      end
      void'(tx_q.pop_front());
      sent++;
      if (gap > 0 && tx_q.size() > 0 && sent < max_bytes) begin
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        start      = poke;
        repeat (gap - 1) begin
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic finish_load(input string tag);
    int g = 0;
    while (!(done || err) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_timeout"}, 64'(g < 2000), 64'd1);
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_nwr"}, 64'(cap_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < cap_q.size() && k < exp_q.size(); k++) begin
      check({tag, "_addr"}, 64'(cap_q[k].addr), 64'(32'(BASE + k)));
      check({tag, "_data"}, 64'(cap_q[k].data), 64'(exp_q[k]));
      check({tag, "_lat"}, 64'(cap_q[k].hs - hs_base), 64'(4 * (k + 2)));
    end
  endtask

  task automatic run_image(input string tag, input int gap, input bit poke);
    begin_load();
    feed(gap, poke, 1 << 20);
    finish_load(tag);
  endtask

  initial begin
    int hs_before;
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_wren", 64'(wr_en), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed N=2 image, continuous stream.
    word_list = '{32'h20080005, 32'h8C090004};
    build_image(32'd2, 1'b0, 32'd0);
    run_image("n2", 0, 1'b0);
    if (cap_q.size() == 2) begin
      check("n2_w0", 64'(cap_q[0].data), 64'h20080005);
      check("n2_w1", 64'(cap_q[1].data), 64'h8C090004);
    end else begin
      check("n2_count", 64'(cap_q.size()), 64'd2);
    end

    // Oversize header: rejected with no writes, further bytes not consumed.
    word_list.delete();
    build_image(32'd1025, 1'b0, 32'd0);
    run_image("over", 0, 1'b0);
    check("over_hs", 64'(hs_cnt - hs_base), 64'd4);
    hs_before = hs_cnt;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check("err_no_consume", 64'(hs_cnt), 64'(hs_before));
    check("err_hold", 64'(err), 64'd1);

    // Gapped stream with start pulses while busy.
    n = $urandom_range(1, 8);
    rand_words(n);
    build_image(32'(n), 1'b0, 32'd0);
    run_image("gap", 2, 1'b1);

    // Empty image.
    word_list.delete();
    build_image(32'd0, 1'b0, 32'd0);
    run_image("n0", 0, 1'b0);

    // start together with a byte in DONE: the byte is not consumed.
    word_list = '{32'hDEADBEEF};
    build_image(32'd1, 1'b0, 32'd0);
    @(negedge clk);
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h00;
    hs_before  = hs_cnt;
    hs_base    = hs_cnt;
    cap_q.delete();
    @(negedge clk);
    check("start_byte_hs", 64'(hs_cnt), 64'(hs_before));
    check("start_busy", 64'(busy), 64'd1);
    check("start_done_clr", 64'(done), 64'd0);
    start      = 1'b0;
    byte_valid = 1'b0;
    feed(0, 1'b0, 1 << 20);
    finish_load("sb");

`ifdef LOADER_CHECKSUM_EN
    // Trailer that does not match the sum of the two words.
    word_list = '{32'h20080005, 32'h8C090004};
    build_image(32'd2, 1'b1, 32'hACF1000A);
    run_image("csum_bad", 0, 1'b0);
    check("csum_bad_err", 64'(err), 64'd1);
    check("csum_bad_done", 64'(done), 64'd0);
`endif

    // Reset in the middle of DATA.
    rand_words(4);
    build_image(32'd4, 1'b0, 32'd0);
    begin_load();
    feed(0, 1'b0, 10);
    tx_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_ready", 64'(byte_ready), 64'd0);
      check("mid_rst_wren", 64'(wr_en), 64'd0);
      check("mid_rst_flags", 64'({done, err, busy}), 64'd0);
      check("mid_rst_bus", 64'({wr_addr, wr_data}), 64'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 64'(byte_ready), 64'd0);

    // Fresh load after reset starts from word 0 with a clean assembler.
    n = $urandom_range(1, 24);
    rand_words(n);
    build_image(32'(n), 1'b0, 32'd0);
    run_image("rand", 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
